mult_fu_pipe: RTL and testbench
===============================

# mult_fu_pipe

Pipelined integer multiply functional unit that feeds the common data bus arbiter. It accepts one issued multiply per cycle from the reservation station and computes the RV32M MUL/MULH/MULHSU/MULHU result over STAGES pipeline stages. It presents the finished result as a mult_prepared/mult_packet pair and holds it stable until the CDB asserts mult_avail. When its output is blocked, it back-pressures the whole pipe and the issue port.

## Interface
- STAGES, 4: pipeline depth and result latency; legal values 1, 2, 4, 8 (must divide 64).
- clock  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-low: state is cleared on a posedge where reset==0.
- issue_valid  in  1  RS presents a multiply this cycle.
- issue_func  in  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- issue_rs1, issue_rs2  in  32 each  operand values.
- issue_robn  in  `ROB_CNT_WIDTH  ROB tag.
- issue_dest_prn  in  `PRN_WIDTH  destination physical register.
- issue_ready  out  1  issue is accepted this cycle if issue_valid.
- squash  in  1  mispredict flush; kills every in-flight op.
- mult_avail  in  1  CDB will take (or has taken) the presented result this cycle.
- mult_prepared  out  1  output stage holds a valid result.
- mult_packet  out  {robn, dest_prn, result[31:0]}  result record; driven from registers only.

## Operation
- Operand prep at issue: rs1 is sign-extended to 64 b for MULH/MULHSU and zero-extended otherwise. rs2 is sign-extended for MULH and zero-extended otherwise. The product is computed modulo 2^64.
- Stage k (1..STAGES) holds: valid, func, robn, dest_prn, mcand[63:0] (shifted), mplier remaining bits, and partial sum [63:0].
- Each stage consumes 64/STAGES multiplier bits. It adds the shifted multiplicand times those bits into the partial sum, shifts mcand left and mplier right by 64/STAGES. The sum wraps at 64 b.
- Output select from the final stage: MUL gives sum[31:0]; the other three functions give sum[63:32].
- mult_packet fields come directly from the final stage registers. When mult_prepared==0, the packet must be all zeros.
- advance = mult_avail | ~mult_prepared. This is one global enable for all stages; there is no bubble collapsing.
- issue_ready = advance.
- When advance==1, stage1 loads the issue (valid = issue_valid), and each stage k+1 loads stage k.
- When advance==0, every stage holds its value, and the issue is not accepted.
- squash==1: all valid bits clear on the next edge. The issue in the same cycle is dropped. squash takes priority over advance and over issue.
- reset==0: all valid bits clear and all datapath registers go to 0. reset takes priority over squash.

## Timing
- Reset values: mult_prepared=0, mult_packet=0, issue_ready=1 (it follows from mult_prepared=0).
- Latency: an op accepted in cycle t appears with mult_prepared=1 in cycle t+STAGES, provided no stall occurs in between. Each stall cycle adds exactly 1 to the latency.
- Throughput: 1 op/cycle while mult_avail stays 1.
- Handshake: mult_prepared and mult_packet remain unchanged while mult_avail==0. A transfer completes at the edge ending a cycle in which mult_prepared==1 and mult_avail==1.
- mult_avail may be 1 while mult_prepared==0; this is a legal idle advance.
- issue_ready depends combinationally on mult_avail (no registered path). The RS must not create a loop back into mult_avail.
- A squash in cycle t gives mult_prepared=0 in cycle t+1, regardless of mult_avail.
- Reset asserted mid-stream gives an empty pipe one cycle later. No stale result may reappear afterwards.

## Test plan
- **Basic MUL:** reset, then issue MUL 7×6, robn=3, prn=9, with mult_avail tied to 1. Required: in cycle t+4, mult_prepared=1 and packet={3, 9, 0x0000002A} for exactly one cycle.
- **Signed variants, back-to-back over 4 cycles:**
  - MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF
  - MUL 0x80000000×2 → 0x00000000
  - Required: results emerge in order on 4 consecutive cycles.
- **Stall:** issue 5 ops, then hold mult_avail=0 for 3 cycles once the first result is prepared. Required: the packet stays stable, issue_ready=0, and there is no loss or duplication. All 5 results come out in order after release, each delayed by exactly 3 cycles.
- **Squash:** fill the pipe with 4 ops, then assert squash together with issue_valid. Required: mult_prepared=0 from the next cycle onward and no result ever appears. A new issue afterwards completes with normal latency.
- **Mid-operation reset:** with ops in flight and mult_avail=0, drive reset=0 for 1 cycle. Required: outputs are zero next cycle and issue_ready=1.
- **Parameter sweep:** repeat the basic and signed-variant scenarios with STAGES=1 and STAGES=8. Required: latencies of 1 and 8 respectively, with identical results.

Source files
------------

// File: rtl/mult_fu_if.sv
// Issue/result bundle between the reservation station, the multiply unit and the CDB arbiter.
interface mult_fu_if #(
  parameter int unsigned ROB_W = 5,
  parameter int unsigned PRN_W = 6
);
  logic                     issue_valid;
  logic [1:0]               issue_func;
  logic [31:0]              issue_rs1;
  logic [31:0]              issue_rs2;
  logic [ROB_W-1:0]         issue_robn;
  logic [PRN_W-1:0]         issue_dest_prn;
  logic                     issue_ready;
  logic                     squash;
  logic                     mult_avail;
  logic                     mult_prepared;
  logic [ROB_W+PRN_W+31:0]  mult_packet;

  modport master (
    output issue_valid, issue_func, issue_rs1, issue_rs2, issue_robn, issue_dest_prn,
    output squash, mult_avail,
    input  issue_ready, mult_prepared, mult_packet
  );

  modport slave (
    input  issue_valid, issue_func, issue_rs1, issue_rs2, issue_robn, issue_dest_prn,
    input  squash, mult_avail,
    output issue_ready, mult_prepared, mult_packet
  );
endinterface

// File: rtl/mult_fu_pipe.sv
// Pipelined RV32M multiplier: each stage retires 64/STAGES multiplier bits into a 64-bit partial sum.
module mult_fu_pipe #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned ROB_W  = 5,
  parameter int unsigned PRN_W  = 6
) (
  input  logic   clock,
  input  logic   reset,
  mult_fu_if.slave fu
);
  localparam int unsigned B    = 64 / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  logic             valid  [STAGES];
  logic [1:0]       func   [STAGES];
  logic [ROB_W-1:0] robn   [STAGES];
  logic [PRN_W-1:0] prn    [STAGES];
  logic [63:0]      mcand  [STAGES];
  logic [63:0]      mplier [STAGES];
  logic [63:0]      sum    [STAGES];

  // Stage inputs: index 0 is the operand-prepped issue, index k is stage k-1.
  logic             in_valid  [STAGES];
  logic [1:0]       in_func   [STAGES];
  logic [ROB_W-1:0] in_robn   [STAGES];
  logic [PRN_W-1:0] in_prn    [STAGES];
  logic [63:0]      in_mcand  [STAGES];
  logic [63:0]      in_mplier [STAGES];
  logic [63:0]      in_sum    [STAGES];

  logic        advance;
  logic        rs1_signed;
  logic        rs2_signed;
  logic [31:0] result;

  assign rs1_signed = (fu.issue_func == 2'd1) || (fu.issue_func == 2'd2);
  assign rs2_signed = (fu.issue_func == 2'd1);
  assign advance    = fu.mult_avail | ~valid[LAST];

  always_comb begin
    in_valid[0]  = fu.issue_valid;
    in_func[0]   = fu.issue_func;
    in_robn[0]   = fu.issue_robn;
    in_prn[0]    = fu.issue_dest_prn;
    in_mcand[0]  = {{32{rs1_signed & fu.issue_rs1[31]}}, fu.issue_rs1};
    in_mplier[0] = {{32{rs2_signed & fu.issue_rs2[31]}}, fu.issue_rs2};
    in_sum[0]    = '0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      in_valid[k]  = valid[k-1];
      in_func[k]   = func[k-1];
      in_robn[k]   = robn[k-1];
      in_prn[k]    = prn[k-1];
      in_mcand[k]  = mcand[k-1];
      in_mplier[k] = mplier[k-1];
      in_sum[k]    = sum[k-1];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid[k]  <= 1'b0;
        func[k]   <= '0;
        robn[k]   <= '0;
        prn[k]    <= '0;
        mcand[k]  <= '0;
        mplier[k] <= '0;
        sum[k]    <= '0;
      end
    end else if (fu.squash) begin
      for (int unsigned k = 0; k < STAGES; k++) valid[k] <= 1'b0;
    end else if (advance) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid[k]  <= in_valid[k];
        func[k]   <= in_func[k];
        robn[k]   <= in_robn[k];
        prn[k]    <= in_prn[k];
        mcand[k]  <= in_mcand[k] << B;
        mplier[k] <= in_mplier[k] >> B;
        sum[k]    <= in_sum[k] + in_mcand[k] * 64'(in_mplier[k][B-1:0]);
      end
    end
  end

  assign result           = (func[LAST] == 2'd0) ? sum[LAST][31:0] : sum[LAST][63:32];
  assign fu.issue_ready   = advance;
  assign fu.mult_prepared = valid[LAST];
  assign fu.mult_packet   = valid[LAST] ? {robn[LAST], prn[LAST], result} : '0;
endmodule

// File: tb/tb_mult_fu_pipe.sv
// Directed bench: one stimulus stream broadcast to STAGES=1/4/8 instances, each checked at its own latency.
module tb_mult_fu_pipe;
  localparam int unsigned ROB_W = 5;
  localparam int unsigned PRN_W = 6;
  localparam int unsigned PKT_W = ROB_W + PRN_W + 32;

  logic clock = 1'b0;
  logic reset;
  logic issue_valid, squash, mult_avail;
  logic [1:0]       issue_func;
  logic [31:0]      issue_rs1, issue_rs2;
  logic [ROB_W-1:0] issue_robn;
  logic [PRN_W-1:0] issue_dest_prn;

  int checks   = 0;
  int failures = 0;

  mult_fu_if #(.ROB_W(ROB_W), .PRN_W(PRN_W)) i1 ();
  mult_fu_if #(.ROB_W(ROB_W), .PRN_W(PRN_W)) i4 ();
  mult_fu_if #(.ROB_W(ROB_W), .PRN_W(PRN_W)) i8 ();

  assign i1.issue_valid = issue_valid; assign i4.issue_valid = issue_valid; assign i8.issue_valid = issue_valid;
  assign i1.issue_func = issue_func; assign i4.issue_func = issue_func; assign i8.issue_func = issue_func;
  assign i1.issue_rs1 = issue_rs1; assign i4.issue_rs1 = issue_rs1; assign i8.issue_rs1 = issue_rs1;
  assign i1.issue_rs2 = issue_rs2; assign i4.issue_rs2 = issue_rs2; assign i8.issue_rs2 = issue_rs2;
  assign i1.issue_robn = issue_robn; assign i4.issue_robn = issue_robn; assign i8.issue_robn = issue_robn;
  assign i1.issue_dest_prn = issue_dest_prn; assign i4.issue_dest_prn = issue_dest_prn; assign i8.issue_dest_prn = issue_dest_prn;
  assign i1.squash = squash; assign i4.squash = squash; assign i8.squash = squash;
  assign i1.mult_avail = mult_avail; assign i4.mult_avail = mult_avail; assign i8.mult_avail = mult_avail;

  mult_fu_pipe #(.STAGES(1), .ROB_W(ROB_W), .PRN_W(PRN_W)) u1 (.clock(clock), .reset(reset), .fu(i1));
  mult_fu_pipe #(.STAGES(4), .ROB_W(ROB_W), .PRN_W(PRN_W)) u4 (.clock(clock), .reset(reset), .fu(i4));
  mult_fu_pipe #(.STAGES(8), .ROB_W(ROB_W), .PRN_W(PRN_W)) u8 (.clock(clock), .reset(reset), .fu(i8));

  initial forever #5 clock = ~clock;

  function automatic logic [PKT_W-1:0] pk(input logic [ROB_W-1:0] r, input logic [PRN_W-1:0] p,
                                          input logic [31:0] v);
    return {r, p, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int s, input logic ev, input logic [PKT_W-1:0] ep);
    logic             gv;
    logic [PKT_W-1:0] gp;
    case (s)
      1:       begin gv = i1.mult_prepared; gp = i1.mult_packet; end
      4:       begin gv = i4.mult_prepared; gp = i4.mult_packet; end
      default: begin gv = i8.mult_prepared; gp = i8.mult_packet; end
    endcase
    chk($sformatf("%s_s%0d_prepared", tag, s), 64'(gv), 64'(ev));
    chk($sformatf("%s_s%0d_packet", tag, s), 64'(gp), 64'(ep));
  endtask

  task automatic chk_rdy(input string tag, input int s, input logic er);
    logic gr;
    case (s)
      1:       gr = i1.issue_ready;
      4:       gr = i4.issue_ready;
      default: gr = i8.issue_ready;
    endcase
    chk($sformatf("%s_s%0d_ready", tag, s), 64'(gr), 64'(er));
  endtask

  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [ROB_W-1:0] r, input logic [PRN_W-1:0] p);
    issue_valid = 1'b1; issue_func = f; issue_rs1 = a; issue_rs2 = b;
    issue_robn = r; issue_dest_prn = p;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_func = '0; issue_rs1 = '0; issue_rs2 = '0;
    issue_robn = '0; issue_dest_prn = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  int sz [3] = '{1, 4, 8};
  logic [1:0]  sf [4] = '{2'd1, 2'd3, 2'd2, 2'd0};
  logic [31:0] sa [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
  logic [31:0] sb [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002};
  logic [31:0] sr [4] = '{32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000};
  logic [31:0] stall_res [5] = '{32'd6, 32'd9, 32'd12, 32'd15, 32'd18};

  initial begin
    reset = 1'b0; squash = 1'b0; mult_avail = 1'b0;
    idle();
    tick();
    tick();
    for (int j = 0; j < 3; j++) begin
      chk_out("reset", sz[j], 1'b0, '0);
      chk_rdy("reset", sz[j], 1'b1);
    end
    reset = 1'b1;

    // Basic MUL 7x6 on all depths
    mult_avail = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 0) issue(2'd0, 32'd7, 32'd6, 5'd3, 6'd9); else idle();
      #1;
      for (int j = 0; j < 3; j++)
        chk_out($sformatf("basic_c%0d", c), sz[j], c == sz[j],
                (c == sz[j]) ? pk(5'd3, 6'd9, 32'h2A) : '0);
      tick();
    end

    // Signed variants back-to-back
    for (int c = 0; c < 13; c++) begin
      if (c < 4) issue(sf[c], sa[c], sb[c], 5'(c + 1), 6'(c + 10)); else idle();
      #1;
      for (int j = 0; j < 3; j++) begin
        int idx;
        idx = c - sz[j];
        if (idx >= 0 && idx < 4)
          chk_out($sformatf("signed_c%0d", c), sz[j], 1'b1, pk(5'(idx + 1), 6'(idx + 10), sr[idx]));
        else
          chk_out($sformatf("signed_c%0d", c), sz[j], 1'b0, '0);
      end
      tick();
    end

    // Stall: output blocked for cycles 4..6, op4 waits at the issue port
    reset_pulse();
    for (int c = 0; c < 13; c++) begin
      mult_avail = !(c >= 4 && c <= 6);
      if (c < 4) issue(2'd0, 32'(c + 2), 32'd3, 5'(c), 6'(c + 20));
      else if (c <= 7) issue(2'd0, 32'd6, 32'd3, 5'd4, 6'd24);
      else idle();
      #1;
      if (c >= 4 && c <= 6) begin
        chk_out($sformatf("stall_c%0d", c), 4, 1'b1, pk(5'd0, 6'd20, stall_res[0]));
        chk_rdy($sformatf("stall_c%0d", c), 4, 1'b0);
      end else if (c >= 7 && c <= 11) begin
        chk_out($sformatf("stall_c%0d", c), 4, 1'b1, pk(5'(c - 7), 6'(c + 13), stall_res[c-7]));
        chk_rdy($sformatf("stall_c%0d", c), 4, 1'b1);
      end else begin
        chk_out($sformatf("stall_c%0d", c), 4, 1'b0, '0);
        chk_rdy($sformatf("stall_c%0d", c), 4, 1'b1);
      end
      tick();
    end

    // Squash with a full pipe and a concurrent issue
    reset_pulse();
    mult_avail = 1'b1;
    for (int c = 0; c < 13; c++) begin
      squash = (c == 4);
      if (c < 4) issue(2'd0, 32'(c + 3), 32'd5, 5'(c), 6'(c));
      else if (c == 4) issue(2'd0, 32'd9, 32'd9, 5'd7, 6'd7);
      else if (c == 6) issue(2'd0, 32'h10, 32'h10, 5'd12, 6'd30);
      else idle();
      #1;
      if (c == 4)       chk_out($sformatf("squash_c%0d", c), 4, 1'b1, pk(5'd0, 6'd0, 32'd15));
      else if (c == 10) chk_out($sformatf("squash_c%0d", c), 4, 1'b1, pk(5'd12, 6'd30, 32'h100));
      else              chk_out($sformatf("squash_c%0d", c), 4, 1'b0, '0);
      tick();
    end
    squash = 1'b0;

    // Reset while ops are in flight and the output is blocked
    mult_avail = 1'b0;
    for (int c = 0; c < 11; c++) begin
      reset = (c != 3);
      if (c < 3) issue(2'd0, 32'(c + 1), 32'(c + 1), 5'(c), 6'(c)); else idle();
      #1;
      if (c >= 4) begin
        for (int j = 0; j < 3; j++) begin
          chk_out($sformatf("midrst_c%0d", c), sz[j], 1'b0, '0);
          chk_rdy($sformatf("midrst_c%0d", c), sz[j], 1'b1);
        end
      end else begin
        chk_out($sformatf("midrst_c%0d", c), 4, 1'b0, '0);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
